// File: rtl/axi_mem_slave.sv
// Word-addressed AXI-style memory slave that services one read or one write at a time.
// Define AXI_MEM_SLAVE_WAIT_EN to add one wait state ahead of each address accept.
module axi_mem_slave #(
   parameter int ADDR_W = 10
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        ARvalid,
   output logic        ARready,
   input  logic [31:0] ARdata,
   output logic        Rvalid,
   input  logic        RReady,
   output logic [31:0] Rdata,
   input  logic        AWvalid,
   output logic        AWready,
   input  logic [31:0] AWdata,
   input  logic        Wvalid,
   output logic        Wready,
   input  logic [31:0] Wdata,
   input  logic [3:0]  Wstrb,
   output logic        Bvalid,
   input  logic        Bready
);

`ifdef AXI_MEM_SLAVE_WAIT_EN
   typedef enum logic [2:0] {IDLE, AR_WAIT, AR_ACK, RD_DATA, W_WAIT, W_ACK, WR_RESP} state_t;
   localparam state_t AR_ENTRY = AR_WAIT;
   localparam state_t W_ENTRY  = W_WAIT;
`else
   typedef enum logic [2:0] {IDLE, AR_ACK, RD_DATA, W_ACK, WR_RESP} state_t;
   localparam state_t AR_ENTRY = AR_ACK;
   localparam state_t W_ENTRY  = W_ACK;
`endif

   state_t state, next_state;
   logic   rd_load, wr_en;

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] rd_index, wr_index;

   // Byte lanes and address bits above the memory depth are ignored, so addresses alias.
   assign rd_index = ARdata[ADDR_W+1:2];
   assign wr_index = AWdata[ADDR_W+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{ARdata[31:ADDR_W+2], ARdata[1:0], AWdata[31:ADDR_W+2], AWdata[1:0]};

   always_comb begin
      next_state = state;
      rd_load    = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (ARvalid)
               next_state = AR_ENTRY;
            else if (AWvalid && Wvalid)
               next_state = W_ENTRY;
         end
`ifdef AXI_MEM_SLAVE_WAIT_EN
         AR_WAIT: next_state = ARvalid ? AR_ACK : IDLE;
         W_WAIT:  next_state = (AWvalid && Wvalid) ? W_ACK : IDLE;
`endif
         AR_ACK: begin
            if (ARvalid) begin
               rd_load    = 1'b1;
               next_state = RD_DATA;
            end else begin
               next_state = IDLE;
            end
         end
         RD_DATA: begin
            if (RReady)
               next_state = IDLE;
         end
         W_ACK: begin
            if (AWvalid && Wvalid) begin
               wr_en      = 1'b1;
               next_state = WR_RESP;
            end else begin
               next_state = IDLE;
            end
         end
         WR_RESP: begin
            if (Bready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are flops loaded from the upcoming state, so they change only on state entry.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= IDLE;
         ARready <= 1'b0;
         Rvalid  <= 1'b0;
         AWready <= 1'b0;
         Wready  <= 1'b0;
         Bvalid  <= 1'b0;
         Rdata   <= '0;
      end else begin
         state   <= next_state;
         ARready <= (next_state == AR_ACK);
         Rvalid  <= (next_state == RD_DATA);
         AWready <= (next_state == W_ACK);
         Wready  <= (next_state == W_ACK);
         Bvalid  <= (next_state == WR_RESP);
         if (rd_load)
            Rdata <= mem[rd_index];
      end
   end

   // Memory is never cleared; a reset edge suppresses any write pending on that edge.
   always_ff @(posedge clock) begin
      if (resetn && wr_en) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (Wstrb[lane])
               mem[wr_index][8*lane +: 8] <= Wdata[8*lane +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: transaction-level memory model plus per-cycle output compare.
// Honours AXI_MEM_SLAVE_WAIT_EN by adding one wait cycle to the expected accept timing.
module tb_axi_mem_slave;

   localparam int ADDR_W = 10;
`ifdef AXI_MEM_SLAVE_WAIT_EN
   localparam int WAITS = 1;
`else
   localparam int WAITS = 0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic        ARvalid, ARready, Rvalid, RReady;
   logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
   logic [31:0] ARdata, Rdata, AWdata, Wdata;
   logic [3:0]  Wstrb;

   logic        expArready, expRvalid, expAwready, expWready, expBvalid;
   logic [31:0] expRdata, lastRdata;
   logic [31:0] modelMem [int];
   logic [31:0] pendAddr, pendData;
   logic [3:0]  pendStrb;
   int          nChecks = 0;
   int          nPass = 0;
   bit          checkEn = 1'b0;

   axi_mem_slave #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .resetn(resetn),
      .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata),
      .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
      .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata),
      .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
      .Bvalid(Bvalid), .Bready(Bready)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got === want)
         nPass++;
      else
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
   endtask

   // Every cycle, mid-period, all outputs are compared against what the model says this cycle shows.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("ARready", 32'(ARready), 32'(expArready));
         checkOutput("Rvalid",  32'(Rvalid),  32'(expRvalid));
         checkOutput("AWready", 32'(AWready), 32'(expAwready));
         checkOutput("Wready",  32'(Wready),  32'(expWready));
         checkOutput("Bvalid",  32'(Bvalid),  32'(expBvalid));
         checkOutput("Rdata",   Rdata,        expRdata);
      end
   end

   function automatic int idxOf(input logic [31:0] addr);
      return int'((addr >> 2) & ((32'd1 << ADDR_W) - 32'd1));
   endfunction

   function automatic logic [31:0] randAddr();
      return (32'($urandom_range(0, 15)) << 2) | ($urandom << (ADDR_W + 2)) | ($urandom & 32'h3);
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int          idx = idxOf(addr);
      logic [31:0] word = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
      for (int i = 0; i < 4; i++)
         if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
      modelMem[idx] = word;
   endtask

   task automatic setIdle();
      expArready = 1'b0;
      expRvalid  = 1'b0;
      expAwready = 1'b0;
      expWready  = 1'b0;
      expBvalid  = 1'b0;
      expRdata   = lastRdata;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         ARvalid = 1'b0; AWvalid = 1'b0; Wvalid = 1'b0; RReady = 1'b0; Bready = 1'b0;
         setIdle();
      end
   endtask

   task automatic finishReset();
      nextCycle();
      resetn = 1'b1;
      ARvalid = 1'b0; AWvalid = 1'b0; Wvalid = 1'b0; RReady = 1'b0; Bready = 1'b0;
      lastRdata = 32'h0;
      setIdle();
   endtask

   task automatic validAlone(input bit awOnly, input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         ARvalid = 1'b0; AWvalid = awOnly; Wvalid = !awOnly;
         AWdata = randAddr(); Wdata = $urandom; Wstrb = 4'hF;
         setIdle();
      end
   endtask

   task automatic doRead(input logic [31:0] addr, input int rwait, input bit holdWrite,
                         input bit abort, output logic [31:0] got);
      int idx = idxOf(addr);
      got = 'x;
      nextCycle();
      ARvalid = 1'b1; ARdata = addr; RReady = 1'b0; Bready = 1'b0;
      AWvalid = holdWrite; Wvalid = holdWrite;
      if (holdWrite) begin
         AWdata = pendAddr; Wdata = pendData; Wstrb = pendStrb;
      end
      setIdle();
      repeat (WAITS) begin
         nextCycle();
         setIdle();
      end
      nextCycle();
      setIdle();
      expArready = 1'b1;
      if (abort) begin
         ARvalid = 1'b0;
         return;
      end
      nextCycle();
      ARvalid = 1'b0; ARdata = $urandom;
      lastRdata = modelMem[idx];
      setIdle();
      expRvalid = 1'b1;
      RReady = (rwait == 0);
      #3 got = Rdata;
      for (int j = 1; j <= rwait; j++) begin
         nextCycle();
         ARdata = $urandom;
         setIdle();
         expRvalid = 1'b1;
         RReady = (j == rwait);
      end
   endtask

   // rstAt: 0 no reset, 1 reset while the write is being accepted, 2 reset while the response waits.
   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bwait, input bit abort, input int rstAt);
      nextCycle();
      ARvalid = 1'b0; RReady = 1'b0; Bready = 1'b0;
      AWvalid = 1'b1; Wvalid = 1'b1; AWdata = addr; Wdata = data; Wstrb = strb;
      setIdle();
      repeat (WAITS) begin
         nextCycle();
         setIdle();
      end
      nextCycle();
      setIdle();
      expAwready = 1'b1;
      expWready  = 1'b1;
      if (abort) begin
         if ($urandom_range(0, 1) == 1) AWvalid = 1'b0;
         else Wvalid = 1'b0;
         return;
      end
      if (rstAt == 1) begin
         resetn = 1'b0;
         finishReset();
         return;
      end
      nextCycle();
      AWvalid = 1'b0; Wvalid = 1'b0; AWdata = $urandom; Wdata = $urandom;
      modelWrite(addr, data, strb);
      setIdle();
      expBvalid = 1'b1;
      if (rstAt == 2) begin
         Bready = 1'b0;
         resetn = 1'b0;
         finishReset();
         return;
      end
      Bready = (bwait == 0);
      for (int j = 1; j <= bwait; j++) begin
         nextCycle();
         setIdle();
         expBvalid = 1'b1;
         Bready = (j == bwait);
      end
   endtask

   task automatic applyStimulus();
      int          kind = $urandom_range(0, 9);
      logic [31:0] addr = randAddr();
      logic [31:0] got;
      case (kind)
         0, 1, 2, 3: doRead(addr, $urandom_range(0, 3), 1'b0, 1'b0, got);
         4, 5, 6, 7: doWrite(addr, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0, 0);
         8: begin
            if ($urandom_range(0, 1) == 1) doRead(addr, 0, 1'b0, 1'b1, got);
            else doWrite(addr, $urandom, 4'hF, 0, 1'b1, 0);
         end
         default: idleCycles($urandom_range(1, 3));
      endcase
   endtask

   initial begin
      logic [31:0] got;
      resetn = 1'b0;
      ARvalid = 1'b0; ARdata = '0; RReady = 1'b0;
      AWvalid = 1'b0; AWdata = '0; Wvalid = 1'b0; Wdata = '0; Wstrb = '0; Bready = 1'b0;
      lastRdata = 32'h0;
      setIdle();
      nextCycle();
      checkEn = 1'b1;
      checkOutput("reset_Rdata", Rdata, 32'h0);
      nextCycle();
      nextCycle();
      resetn = 1'b1;
      idleCycles(2);

      doWrite(32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
      doRead(32'h10, 0, 1'b0, 1'b0, got);
      checkOutput("read_0x10", got, 32'hDEADBEEF);

      doWrite(32'h20, 32'h11223344, 4'hF, 1, 1'b0, 0);
      doWrite(32'h20, 32'h00AA0000, 4'b0100, 0, 1'b0, 0);
      checkOutput("model_0x20", modelMem[8], 32'h11AA3344);
      doRead(32'h20, 0, 1'b0, 1'b0, got);
      checkOutput("read_0x20_strb", got, 32'h11AA3344);

      doWrite(32'h24, 32'hCAFEF00D, 4'hF, 2, 1'b0, 0);
      doRead(32'h24, 5, 1'b0, 1'b0, got);
      checkOutput("read_0x24_stall", got, 32'hCAFEF00D);

      pendAddr = 32'h28; pendData = 32'h12345678; pendStrb = 4'hF;
      doRead(32'h10, 2, 1'b1, 1'b0, got);
      checkOutput("read_first_collide", got, 32'hDEADBEEF);
      doWrite(pendAddr, pendData, pendStrb, 0, 1'b0, 0);
      doRead(32'h28, 0, 1'b0, 1'b0, got);
      checkOutput("read_after_collide", got, 32'h12345678);

      doWrite(32'h0000_1004, 32'h55, 4'hF, 0, 1'b0, 0);
      doRead(32'h4, 1, 1'b0, 1'b0, got);
      checkOutput("read_alias_0x4", got, 32'h55);
      validAlone(1'b1, 4);
      validAlone(1'b0, 4);

      doWrite(32'h10, 32'hFFFFFFFF, 4'h0, 1, 1'b0, 0);
      doRead(32'h10, 0, 1'b0, 1'b0, got);
      checkOutput("read_strb_zero", got, 32'hDEADBEEF);

      doWrite(32'h30, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 2);
      doRead(32'h30, 0, 1'b0, 1'b0, got);
      checkOutput("read_after_resp_reset", got, 32'hA5A5A5A5);
      doWrite(32'h30, 32'h0BAD0BAD, 4'hF, 0, 1'b0, 1);
      doRead(32'h30, 0, 1'b0, 1'b0, got);
      checkOutput("read_after_ack_reset", got, 32'hA5A5A5A5);

      doRead(32'h24, 0, 1'b0, 1'b1, got);
      doWrite(32'h10, 32'h0, 4'hF, 0, 1'b1, 0);
      doRead(32'h10, 0, 1'b0, 1'b0, got);
      checkOutput("read_after_aborts", got, 32'hDEADBEEF);

      for (int i = 0; i < 16; i++)
         doWrite(32'(i) << 2, $urandom, 4'hF, 0, 1'b0, 0);
      for (int i = 0; i < 250; i++)
         applyStimulus();

      idleCycles(2);
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
